// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised 16x-oversampled UART receiver with output FIFO.
//
// Ports:
//   clk, reset      system clock; synchronous active-low reset
//   baud_rate       00=2400 01=4800 10=9600 11=19200 (latched per frame)
//   parity_type     00/11=none 01=odd 10=even (latched per frame)
//   din             asynchronous serial line, idle high
//   out/parity_bit/parity_err/frame_err/out_valid
//                   first-word-fall-through view of the FIFO head entry
//   out_ready       pop request, honoured when out_valid is high
//   recieve_flag    one-cycle pulse per completed frame (also for dropped frames)
//   break_det       one-cycle pulse for an all-zero frame with a framing error
//   overflow        sticky: a completed frame was dropped on a full FIFO
//   fifo_count      FIFO occupancy
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  baud_rate,
  input  logic [1:0]                  parity_type,
  input  logic                        din,
  output logic [DATA_BITS-1:0]        out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        parity_bit,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        recieve_flag,
  output logic                        break_det,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  // Rounded divisors: round(CLK_FREQ / (BAUD*16))
  localparam int DIV0 = (CLK_FREQ + 2400 * 8) / (2400 * 16);
  localparam int DIV1 = (CLK_FREQ + 4800 * 8) / (4800 * 16);
  localparam int DIV2 = (CLK_FREQ + 9600 * 8) / (9600 * 16);
  localparam int DIV3 = (CLK_FREQ + 19200 * 8) / (19200 * 16);
  localparam int TW   = $clog2(DIV0 + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int BW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  typedef struct packed {
    logic                 par;
    logic                 perr;
    logic                 ferr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  function automatic logic [TW-1:0] div_m1(input logic [1:0] sel);
    case (sel)
      2'd0:    div_m1 = TW'(DIV0 - 1);
      2'd1:    div_m1 = TW'(DIV1 - 1);
      2'd2:    div_m1 = TW'(DIV2 - 1);
      default: div_m1 = TW'(DIV3 - 1);
    endcase
  endfunction

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [3:0]           tidx_q, tidx_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bit_q, par_bit_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [1:0]           baud_q, baud_d, ptype_q, ptype_d;
  logic                 done_q, done_d;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic   din_s, fall, tick, mid, last, maj, par_en;
  logic   push, pop, full, wr_en;
  entry_t head, entry;

  // Receive path: synchroniser, tick generator, frame FSM
  always_comb begin
    sync1_d   = din;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    din_s     = sync2_q;
    fall      = prev_q & ~sync2_q;
    tick      = (tcnt_q == '0);
    tcnt_d    = tick ? div_m1(baud_q) : tcnt_q - TW'(1);
    tidx_d    = tick ? tidx_q + 4'd1 : tidx_q;
    s7_d      = (tick && tidx_q == 4'd7) ? din_s : s7_q;
    s8_d      = (tick && tidx_q == 4'd8) ? din_s : s8_q;
    mid       = tick && (tidx_q == 4'd9);
    last      = tick && (tidx_q == 4'd15);
    // Third vote is the live sample taken on tick 9
    maj       = (s7_q & s8_q) | (s7_q & din_s) | (s8_q & din_s);
    par_en    = (ptype_q == 2'b01) || (ptype_q == 2'b10);
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    data_d    = data_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    baud_d    = baud_q;
    ptype_d   = ptype_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d   = S_START;
          baud_d    = baud_rate;
          ptype_d   = parity_type;
          tcnt_d    = div_m1(baud_rate);
          tidx_d    = '0;
          bcnt_d    = '0;
          par_bit_d = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        if (mid && maj) state_d = S_IDLE;      // glitch, not a start bit
        else if (last) begin
          state_d = S_DATA;
          bcnt_d  = '0;
        end
      end
      S_DATA: begin
        if (mid) data_d = {maj, data_q[DATA_BITS-1:1]};
        if (last) begin
          if (bcnt_q == BW'(DATA_BITS - 1)) begin
            bcnt_d  = '0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (mid) begin
          par_bit_d = maj;
          perr_d    = (ptype_q == 2'b10) ? (^data_q ^ maj) : ~(^data_q ^ maj);
        end
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        if (mid) begin
          if (!maj) ferr_d = 1'b1;
          // Complete at the last stop bit's mid-sample so a back-to-back
          // start edge half a bit later is not missed.
          if (bcnt_q == BW'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = (ferr_q | ~maj) ? S_WAIT_IDLE : S_IDLE;
          end
        end else if (last) begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_WAIT_IDLE: begin
        // Hold off while the line is low so a break yields one frame only
        if (din_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: first-word-fall-through, one write per completed frame
  always_comb begin
    entry.par  = par_bit_q;
    entry.perr = perr_q;
    entry.ferr = ferr_q;
    entry.data = data_q;
    push   = done_q;
    pop    = (cnt_q != '0) && out_ready;
    full   = (cnt_q == CW'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the slot being overwritten
    wr_en  = push && (!full || pop);
    mem_d  = mem_q;
    if (wr_en) mem_d[wr_q] = entry;
    wr_d   = wr_en ? wr_q + PW'(1) : wr_q;
    rd_d   = pop ? rd_q + PW'(1) : rd_q;
    cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
    ovf_d  = ovf_q | (push && full && !pop);
    head   = mem_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      tcnt_q    <= '0;
      tidx_q    <= '0;
      bcnt_q    <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      baud_q    <= '0;
      ptype_q   <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      tcnt_q    <= tcnt_d;
      tidx_q    <= tidx_d;
      bcnt_q    <= bcnt_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      data_q    <= data_d;
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      baud_q    <= baud_d;
      ptype_q   <= ptype_d;
      done_q    <= done_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Head fields are forced to zero while empty so reset leaves all outputs low
  assign out_valid    = (cnt_q != '0);
  assign out          = out_valid ? head.data : '0;
  assign parity_bit   = out_valid & head.par;
  assign parity_err   = out_valid & head.perr;
  assign frame_err    = out_valid & head.ferr;
  assign recieve_flag = done_q;
  assign break_det    = done_q & (data_q == '0) & ~par_bit_q & ferr_q;
  assign overflow     = ovf_q;
  assign fifo_count   = cnt_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed frames at a scaled 2 MHz clock so the
// whole plan fits in a short run. Two instances: default 8/1 and 7-bit, 2-stop.
module tb_uart_rx_param;
  localparam int CLK_FREQ = 2_000_000;
  // 16 * round(2e6 / (baud*16)): 19200 -> 7, 9600 -> 13, 2400 -> 52
  localparam int B19200 = 112;
  localparam int B9600  = 208;
  localparam int B2400  = 832;

  typedef struct packed {
    logic [8:0] d;
    logic       pb;
    logic       pe;
    logic       fe;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] baud, par, baud7, par7;
  logic       din, din7, rdy, rdy7;
  logic [7:0] out;
  logic [6:0] out7;
  logic       ov, pb, pe, fe, rf, bd, ovf;
  logic       ov7, pb7, pe7, fe7, rf7, bd7, ovf7;
  logic [2:0] cnt, cnt7;

  int  total = 0;
  int  bad   = 0;
  int  rf_n  = 0;
  int  bd_n  = 0;
  int  rf7_n = 0;
  sb_t exp_q[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk), .reset(rst_n), .baud_rate(baud), .parity_type(par), .din(din),
    .out(out), .out_valid(ov), .out_ready(rdy), .parity_bit(pb),
    .parity_err(pe), .frame_err(fe), .recieve_flag(rf), .break_det(bd),
    .overflow(ovf), .fifo_count(cnt)
  );

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clk(clk), .reset(rst_n), .baud_rate(baud7), .parity_type(par7), .din(din7),
    .out(out7), .out_valid(ov7), .out_ready(rdy7), .parity_bit(pb7),
    .parity_err(pe7), .frame_err(fe7), .recieve_flag(rf7), .break_det(bd7),
    .overflow(ovf7), .fifo_count(cnt7)
  );

  always @(negedge clk) begin
    if (rf)  rf_n  <= rf_n + 1;
    if (bd)  bd_n  <= bd_n + 1;
    if (rf7) rf7_n <= rf7_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input bit w, input int cycles);
    if (w) din7 = 1'b1; else din = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Shift out n line levels LSB first, each lasting one bit period
  task automatic send_bits(input bit w, input logic [31:0] bits, input int n, input int bitlen);
    for (int i = 0; i < n; i++) begin
      if (w) din7 = bits[i]; else din = bits[i];
      repeat (bitlen) @(negedge clk);
    end
  endtask

  task automatic send_frame(input bit w, input logic [31:0] bits, input int n, input int bitlen);
    send_bits(w, bits, n, bitlen);
    idle(w, bitlen);
  endtask

  task automatic push_exp(input logic [8:0] d, input logic p, input logic e, input logic f);
    sb_t s;
    s.d = d; s.pb = p; s.pe = e; s.fe = f;
    exp_q.push_back(s);
  endtask

  task automatic pop_check(input bit w, input string tag);
    sb_t e;
    bit  ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (w ? ov7 : ov) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(ok), 32'd1);
    if (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, w ? 32'(out7) : 32'(out), 32'(e.d));
      chk({tag, "_pbit"}, w ? 32'(pb7) : 32'(pb), 32'(e.pb));
      chk({tag, "_perr"}, w ? 32'(pe7) : 32'(pe), 32'(e.pe));
      chk({tag, "_ferr"}, w ? 32'(fe7) : 32'(fe), 32'(e.fe));
      if (w) rdy7 = 1'b1; else rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      rdy7 = 1'b0;
    end
  endtask

  initial begin
    int r0, b0;
    rst_n = 1'b0;
    din = 1'b1; din7 = 1'b1; rdy = 1'b0; rdy7 = 1'b0;
    baud = 2'd3; par = 2'd0; baud7 = 2'd0; par7 = 2'd2;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_flags", {28'd0, rf, bd, pe, fe}, 0);
    chk("rst_out", 32'(out), 0);
    rst_n = 1'b1;
    idle(0, 20);

    // 19200 even parity, 0xA5 with parity 0
    baud = 2'd3; par = 2'd2;
    r0 = rf_n; b0 = bd_n;
    push_exp(9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, B19200);
    chk("a5_rflag", 32'(rf_n - r0), 1);
    chk("a5_break", 32'(bd_n - b0), 0);
    chk("a5_count", 32'(cnt), 1);
    pop_check(0, "a5");
    chk("a5_count_after_pop", 32'(cnt), 0);

    // 19200 odd parity, 0x3C with bad then good parity bit
    par = 2'd1;
    push_exp(9'h03C, 1'b0, 1'b1, 1'b0);
    send_frame(0, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, B19200);
    push_exp(9'h03C, 1'b1, 1'b0, 1'b0);
    send_frame(0, {1'b1, 1'b1, 8'h3C, 1'b0}, 11, B19200);
    chk("odd_count", 32'(cnt), 2);
    pop_check(0, "odd_p0");
    pop_check(0, "odd_p1");

    // 9600 no parity: 0x55 with stop low for 2 bits, then 0x12
    baud = 2'd2; par = 2'd0;
    r0 = rf_n; b0 = bd_n;
    push_exp(9'h055, 1'b0, 1'b0, 1'b1);
    send_frame(0, {1'b0, 1'b0, 8'h55, 1'b0}, 11, B9600);
    push_exp(9'h012, 1'b0, 1'b0, 1'b0);
    send_frame(0, {1'b1, 8'h12, 1'b0}, 10, B9600);
    chk("ferr_rflag", 32'(rf_n - r0), 2);
    chk("ferr_break", 32'(bd_n - b0), 0);
    pop_check(0, "ferr55");
    pop_check(0, "after12");

    // 19200 short glitch: rejected, receiver stays usable
    baud = 2'd3;
    r0 = rf_n;
    din = 1'b0;
    repeat (10) @(negedge clk);
    idle(0, 3 * B19200);
    chk("glitch_rflag", 32'(rf_n - r0), 0);
    chk("glitch_count", 32'(cnt), 0);
    chk("glitch_valid", 32'(ov), 0);
    push_exp(9'h05A, 1'b0, 1'b0, 1'b0);
    send_frame(0, {1'b1, 8'h5A, 1'b0}, 10, B19200);
    pop_check(0, "post_glitch");

    // Overflow: five frames into a 4-deep FIFO with no pops
    r0 = rf_n;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) push_exp(9'(i), 1'b0, 1'b0, 1'b0);
      send_frame(0, {1'b1, 8'(i), 1'b0}, 10, B19200);
    end
    chk("ovf_rflag", 32'(rf_n - r0), 5);
    chk("ovf_count", 32'(cnt), 4);
    chk("ovf_flag", 32'(ovf), 1);
    for (int i = 1; i <= 4; i++) pop_check(0, "ovf_pop");
    chk("ovf_drained", 32'(cnt), 0);

    // Break: line low for 15 bit periods
    r0 = rf_n; b0 = bd_n;
    push_exp(9'h000, 1'b0, 1'b0, 1'b1);
    send_frame(0, 32'h0, 15, B19200);
    chk("brk_rflag", 32'(rf_n - r0), 1);
    chk("brk_det", 32'(bd_n - b0), 1);
    pop_check(0, "brk");
    chk("ovf_sticky", 32'(ovf), 1);

    // 7 data bits, 2 stop bits, 2400 even parity, second stop low
    r0 = rf7_n;
    push_exp(9'h041, 1'b0, 1'b0, 1'b1);
    send_frame(1, {1'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 11, B2400);
    chk("d7_rflag", 32'(rf7_n - r0), 1);
    pop_check(1, "d7");

    // Reset in the middle of a frame
    baud = 2'd3; par = 2'd0;
    send_frame(0, {1'b1, 8'h33, 1'b0}, 10, B19200);
    chk("pre_rst_count", 32'(cnt), 1);
    r0 = rf_n;
    send_bits(0, {8'h77, 1'b0}, 5, B19200);
    rst_n = 1'b0;
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(ov), 0);
    chk("mid_rst_count", 32'(cnt), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_flags", {27'd0, rf, bd, pb, pe, fe}, 0);
    idle(0, 12 * B19200);
    chk("mid_rst_rflag", 32'(rf_n - r0), 0);
    chk("mid_rst_count_late", 32'(cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
